// File: rtl/rx_demap_pkg.sv
// Shared types and configuration check for the RX resource demapper.
package rx_demap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Allocation must be non-empty and fit inside one OFDM symbol.
  function automatic logic cfg_ok(input int unsigned sc_start,
                                  input int unsigned sc_len,
                                  input int unsigned nfft);
    return (sc_len != 0) && ((sc_start + sc_len) <= nfft);
  endfunction

endpackage

// File: rtl/demap_addr_gen.sv
// Symbol/subcarrier counters and RAM address generation, shared by the
// full-symbol write sweep and the allocated-subcarrier read sweep.
module demap_addr_gen
  import rx_demap_pkg::*;
#(
  parameter int unsigned P_NFFT   = 1024,
  parameter int unsigned P_NSYM   = 14,
  parameter int unsigned P_SC_W   = 10,
  parameter int unsigned P_SYM_W  = 4,
  parameter int unsigned P_ADDR_W = 14
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_adv,
  input  logic                i_rd_mode,
  input  logic [P_SC_W-1:0]   i_sc_start,
  input  logic [P_SC_W:0]     i_sc_len,
  output logic [P_ADDR_W-1:0] o_addr,
  output logic [P_SYM_W-1:0]  o_sym,
  output logic                o_last
);

  logic [P_SC_W-1:0]  sc_q, sc_d;
  logic [P_SYM_W-1:0] sym_q, sym_d;
  logic               sc_wrap;
  logic               sym_wrap;
  logic [P_SC_W:0]    col;

  // In read mode sc_q acts as the offset k into the allocation.
  always_comb begin
    sc_wrap  = i_rd_mode ? ({1'b0, sc_q} == (i_sc_len - (P_SC_W+1)'(1)))
                         : (sc_q == P_SC_W'(P_NFFT - 1));
    sym_wrap = (sym_q == P_SYM_W'(P_NSYM - 1));
    col      = i_rd_mode ? ({1'b0, i_sc_start} + {1'b0, sc_q}) : {1'b0, sc_q};
    sc_d     = sc_q;
    sym_d    = sym_q;
    if (i_clr) begin
      sc_d  = '0;
      sym_d = '0;
    end else if (i_adv) begin
      if (sc_wrap) begin
        sc_d  = '0;
        sym_d = sym_wrap ? '0 : sym_q + P_SYM_W'(1);
      end else begin
        sc_d  = sc_q + P_SC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sc_q  <= '0;
      sym_q <= '0;
    end else begin
      sc_q  <= sc_d;
      sym_q <= sym_d;
    end
  end

  assign o_addr = (P_ADDR_W'(sym_q) << P_SC_W) + P_ADDR_W'(col);
  assign o_sym  = sym_q;
  assign o_last = sc_wrap & sym_wrap;

endmodule

// File: rtl/resource_demapper_ctrl.sv
// Buffers one slot of FFT output into RAM, then reads back only the
// allocated subcarriers of every symbol to the downstream consumer.
module resource_demapper_ctrl
  import rx_demap_pkg::*;
#(
  parameter int unsigned P_NFFT    = 1024,
  parameter int unsigned P_NSYM    = 14,
  localparam int unsigned P_SC_W   = $clog2(P_NFFT),
  localparam int unsigned P_ADDR_W = $clog2(P_NFFT * P_NSYM),
  localparam int unsigned P_SYM_W  = (P_NSYM > 1) ? $clog2(P_NSYM) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sync_clr,
  input  logic                i_fft_valid,
  input  logic [P_SC_W-1:0]   i_sc_start,
  input  logic [P_SC_W:0]     i_sc_len,
  output logic                o_ram_we,
  output logic [P_ADDR_W-1:0] o_ram_waddr,
  output logic                o_ram_re,
  output logic [P_ADDR_W-1:0] o_ram_raddr,
  input  logic                i_out_ready,
  output logic                o_out_valid,
  output logic [P_SYM_W-1:0]  o_sym_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cfg_err,
  output logic                o_drop
);

  state_e              state_q;
  logic [P_SC_W-1:0]   sc_start_q;
  logic [P_SC_W:0]     sc_len_q;
  logic                out_valid_q;
  logic                done_q;
  logic                cfg_err_q;
  logic                drop_q;

  logic                cfg_ok_c;
  logic                we_c;
  logic                re_c;
  logic                rd_mode_c;
  logic                last_c;
  logic [P_ADDR_W-1:0] addr_c;
  logic [P_SYM_W-1:0]  sym_c;

  assign cfg_ok_c  = cfg_ok(32'(i_sc_start), 32'(i_sc_len), P_NFFT);
  assign rd_mode_c = (state_q == ST_READ);

  // RAM strobes follow the inputs within the cycle; sync clear masks them.
  always_comb begin
    we_c = 1'b0;
    re_c = 1'b0;
    if (!i_sync_clr) begin
      case (state_q)
        ST_IDLE:  we_c = i_fft_valid & cfg_ok_c;
        ST_WRITE: we_c = i_fft_valid;
        ST_READ:  re_c = i_out_ready;
        default:  ;
      endcase
    end
  end

  demap_addr_gen #(
    .P_NFFT   (P_NFFT),
    .P_NSYM   (P_NSYM),
    .P_SC_W   (P_SC_W),
    .P_SYM_W  (P_SYM_W),
    .P_ADDR_W (P_ADDR_W)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_sync_clr),
    .i_adv      (we_c | re_c),
    .i_rd_mode  (rd_mode_c),
    .i_sc_start (sc_start_q),
    .i_sc_len   (sc_len_q),
    .o_addr     (addr_c),
    .o_sym      (sym_c),
    .o_last     (last_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sc_start_q  <= '0;
      sc_len_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      // An issued read always yields its data, even across a sync clear.
      out_valid_q <= re_c;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      drop_q      <= 1'b0;
      if (i_sync_clr) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_fft_valid) begin
              if (cfg_ok_c) begin
                sc_start_q <= i_sc_start;
                sc_len_q   <= i_sc_len;
                state_q    <= ST_WRITE;
              end else begin
                cfg_err_q  <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            if (we_c && last_c) state_q <= ST_READ;
          end
          ST_READ: begin
            drop_q <= i_fft_valid;
            if (re_c && last_c) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          default: begin
            drop_q  <= i_fft_valid;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ram_we    = we_c;
  assign o_ram_re    = re_c;
  assign o_ram_waddr = addr_c;
  assign o_ram_raddr = addr_c;
  assign o_out_valid = out_valid_q;
  assign o_done      = done_q;
  assign o_cfg_err   = cfg_err_q;
  assign o_drop      = drop_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_sym_idx   = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? sym_c : '0;

endmodule

// File: tb/tb_resource_demapper_ctrl.sv
// Scoreboard bench for resource_demapper_ctrl with P_NFFT=8, P_NSYM=2.
module tb_resource_demapper_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sync_clr;
  logic       fft_valid;
  logic [2:0] sc_start;
  logic [3:0] sc_len;
  logic       ram_we;
  logic [3:0] ram_waddr;
  logic       ram_re;
  logic [3:0] ram_raddr;
  logic       out_ready;
  logic       out_valid;
  logic [0:0] sym_idx;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic       drop;

  int checks = 0;
  int failures = 0;
  int wq[$];
  int rq[$];
  bit vq[$];
  int exp_done = 0, exp_cfg_err = 0, exp_drop = 0;
  int obs_done = 0, obs_cfg_err = 0, obs_drop = 0;
  logic prev_re;
  logic [31:0] e;
  bit pat[10];

  resource_demapper_ctrl #(.P_NFFT(8), .P_NSYM(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sync_clr  (sync_clr),
    .i_fft_valid (fft_valid),
    .i_sc_start  (sc_start),
    .i_sc_len    (sc_len),
    .o_ram_we    (ram_we),
    .o_ram_waddr (ram_waddr),
    .o_ram_re    (ram_re),
    .o_ram_raddr (ram_raddr),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_sym_idx   (sym_idx),
    .o_busy      (busy),
    .o_done      (done),
    .o_cfg_err   (cfg_err),
    .o_drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes/reads/output beats as the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_re = 1'b0;
    end else begin
      if (ram_we) begin
        if (wq.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          e = wq.pop_front();
          chk("waddr", 32'(ram_waddr), e);
          chk("we_sym_idx", 32'(sym_idx), 32'(e[3]));
        end
      end
      if (ram_re) begin
        if (rq.size() == 0) chk("unexpected_re", 1, 0);
        else begin
          e = rq.pop_front();
          chk("raddr", 32'(ram_raddr), e);
          chk("re_sym_idx", 32'(sym_idx), 32'(e[3]));
        end
      end
      chk("valid_follows_re", 32'(out_valid), 32'(prev_re));
      if (out_valid) begin
        if (vq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("done_with_valid", 32'(done), 32'(vq.pop_front()));
      end else if (done) begin
        chk("done_without_valid", 1, 0);
      end
      obs_done    += int'(done);
      obs_cfg_err += int'(cfg_err);
      obs_drop    += int'(drop);
      prev_re = ram_re;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reads(input int st, input int ln, input bit with_done);
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < ln; k++) begin
        rq.push_back(s * 8 + st + k);
        vq.push_back(with_done && (s == 1) && (k == ln - 1));
      end
    if (with_done) exp_done++;
  endtask

  task automatic write_slot(input int st, input int ln);
    sc_start  = 3'(st);
    sc_len    = 4'(ln);
    fft_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wq.push_back(i);
      tick();
    end
    fft_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 0);
    chk({tag, "_re"}, 32'(ram_re), 0);
    chk({tag, "_raddr"}, 32'(ram_raddr), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_sym_idx"}, 32'(sym_idx), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    chk({tag, "_drop"}, 32'(drop), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0; fft_valid = 1'b0;
    sc_start = '0; sc_len = '0; out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Continuous valid, start=2 len=3.
    out_ready = 1'b1;
    push_reads(2, 3, 1'b1);
    write_slot(2, 3);
    wait_idle();

    // Valid toggled during WRITE; full-width allocation start=0 len=8.
    push_reads(0, 8, 1'b1);
    sc_start = 3'd0;
    sc_len   = 4'd8;
    for (int i = 0; i < 31; i++) begin
      fft_valid = ((i % 2) == 0);
      if (fft_valid) wq.push_back(i / 2);
      else begin
        #1;
        chk("gap_no_we", 32'(ram_we), 0);
        chk("gap_waddr_held", 32'(ram_waddr), 32'(i / 2 + 1));
      end
      tick();
    end
    fft_valid = 1'b0;
    wait_idle();

    // Invalid configurations: overflow past NFFT, and zero length.
    sc_start = 3'd6; sc_len = 4'd3; fft_valid = 1'b1;
    exp_cfg_err++;
    tick();
    fft_valid = 1'b0;
    chk("cfg_err_busy", 32'(busy), 0);
    sc_start = 3'd0; sc_len = 4'd0; fft_valid = 1'b1;
    exp_cfg_err++;
    tick();
    fft_valid = 1'b0;
    chk("len0_busy", 32'(busy), 0);
    tick(); tick();

    // Ready low for two cycles mid-READ, start=1 len=4.
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    push_reads(1, 4, 1'b1);
    write_slot(1, 4);
    for (int i = 0; i < 10; i++) begin
      out_ready = pat[i];
      if (!pat[i]) begin
        #1;
        chk("stall_no_re", 32'(ram_re), 0);
        chk("stall_raddr_held", 32'(ram_raddr), 3);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Sample arriving during READ is dropped.
    out_ready = 1'b0;
    push_reads(0, 2, 1'b1);
    write_slot(0, 2);
    fft_valid = 1'b1;
    exp_drop++;
    tick();
    fft_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Sync clear in WRITE at waddr 5, then a clean restart.
    sc_start = 3'd0; sc_len = 4'd2; fft_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wq.push_back(i);
      tick();
    end
    chk("pre_clr_waddr", 32'(ram_waddr), 5);
    sync_clr = 1'b1;
    #1;
    chk("clr_masks_we", 32'(ram_we), 0);
    tick();
    sync_clr = 1'b0;
    fft_valid = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_waddr", 32'(ram_waddr), 0);
    tick();
    push_reads(0, 2, 1'b1);
    write_slot(0, 2);
    wait_idle();

    // Async reset in READ while an output beat is valid.
    out_ready = 1'b0;
    write_slot(3, 5);
    out_ready = 1'b1;
    rq.push_back(3); rq.push_back(4);
    vq.push_back(1'b0);
    tick(); tick();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    push_reads(3, 5, 1'b1);
    write_slot(3, 5);
    wait_idle();

    tick(); tick();
    chk("wq_empty", 32'(wq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
    chk("vq_empty", 32'(vq.size()), 0);
    chk("done_count", 32'(obs_done), 32'(exp_done));
    chk("cfg_err_count", 32'(obs_cfg_err), 32'(exp_cfg_err));
    chk("drop_count", 32'(obs_drop), 32'(exp_drop));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
